// File: rtl/hcf_pkg.sv
// hcf_pkg: shared state encoding and width helper for the hcf_seq engine
package hcf_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cw_of(input int n);
    return $clog2(2 * n + 2);
  endfunction
endpackage

// File: rtl/hcf_step.sv
// hcf_step: one combinational Stein-GCD reduction step in priority order
module hcf_step
  import hcf_pkg::*;
#(
  parameter int N = 8,
  localparam int KW = $clog2(N + 1)
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  a_nxt,
  output logic [N-1:0]  b_nxt,
  output logic [KW-1:0] k_nxt,
  output logic          eq
);
  logic ae, be, gt;
  // equal ends the loop; shared twos go into k; odd-odd subtracts the smaller and halves
  always_comb begin
    eq = a == b;
    ae = ~a[0];
    be = ~b[0];
    gt = a > b;
    a_nxt = eq ? a : ae ? a >> 1 : be ? a : gt ? (a - b) >> 1 : a;
    b_nxt = eq ? b : be ? b >> 1 : ae ? b : gt ? b : (b - a) >> 1;
    k_nxt = !eq && ae && be ? k + KW'(1) : k;
  end
endmodule

// File: rtl/hcf_seq.sv
// hcf_seq: sequential binary-GCD engine with valid/ready handshakes
module hcf_seq
  import hcf_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = cw_of(N),
  localparam int KW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  hcf,
  output logic          coprime,
  output logic [CW-1:0] cycles,
  output logic          busy
);
  state_t        state;
  logic [N-1:0]  a, b, a_nxt, b_nxt, res, ored;
  logic [KW-1:0] k, k_nxt;
  logic [CW-1:0] cnt;
  logic          eq;
  hcf_step #(.N(N)) u_step (
    .a(a), .b(b), .k(k), .a_nxt(a_nxt), .b_nxt(b_nxt), .k_nxt(k_nxt), .eq(eq)
  );
  assign res       = a << k;
  assign ored      = in1 | in2;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // handshake FSM; result registers only change on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      k       <= '0;
      cnt     <= '0;
      hcf     <= '0;
      coprime <= 1'b0;
      cycles  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (in1 == '0 || in2 == '0) begin
            hcf     <= ored;
            coprime <= ored == N'(1);
            cycles  <= '0;
            state   <= DONE;
          end else begin
            a     <= in1;
            b     <= in2;
            k     <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          a   <= a_nxt;
          b   <= b_nxt;
          k   <= k_nxt;
          if (eq) begin
            hcf     <= res;
            coprime <= res == N'(1);
            cycles  <= cnt + CW'(1);
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hcf_seq.sv
// tb_hcf_seq: directed table, corner sequences and random sweep for hcf_seq
module tb_hcf_seq;
  logic       clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] in1 = 0, in2 = 0;
  logic       in_ready, out_valid, coprime, busy;
  logic [7:0] hcf;
  logic [4:0] cycles;
  int tests = 0, fails = 0;

  hcf_seq #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .hcf(hcf), .coprime(coprime), .cycles(cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x, y, h;
    logic       c;
    int         cy;
  } vec_t;
  vec_t v[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic apply(input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", int'(in_ready), 1);
    in1 = x;
    in2 = y;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    in1 = 8'($urandom);
    in2 = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  // handshake invariants sampled away from the active edge
  always @(negedge clk) if (!rst) begin
    if (in_ready && out_valid) check("ready_valid_overlap", 1, 0);
    if (busy == in_ready) check("busy_vs_ready", int'(busy), int'(!in_ready));
  end

  initial begin
    int lat;
    logic [7:0] x, y;
    v[0] = '{8'd48,  8'd18,  8'd6,   1'b0, 6};
    v[1] = '{8'd17,  8'd5,   8'd1,   1'b1, 5};
    v[2] = '{8'd255, 8'd255, 8'd255, 1'b0, 1};
    v[3] = '{8'd0,   8'd35,  8'd35,  1'b0, 0};
    v[4] = '{8'd0,   8'd0,   8'd0,   1'b0, 0};
    v[5] = '{8'd12,  8'd8,   8'd4,   1'b0, 5};
    v[6] = '{8'd1,   8'd0,   8'd1,   1'b1, 0};
    v[7] = '{8'd1,   8'd1,   8'd1,   1'b1, 1};
    v[8] = '{8'd128, 8'd64,  8'd64,  1'b0, 8};
    v[9] = '{8'd7,   8'd3,   8'd1,   1'b1, 4};

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hcf", int'(hcf), 0);
    check("rst_coprime", int'(coprime), 0);
    check("rst_cycles", int'(cycles), 0);

    for (int i = 0; i < 10; i++) begin
      apply(v[i].x, v[i].y, lat);
      check($sformatf("vec%0d_hcf", i), int'(hcf), int'(v[i].h));
      check($sformatf("vec%0d_coprime", i), int'(coprime), int'(v[i].c));
      check($sformatf("vec%0d_cycles", i), int'(cycles), v[i].cy);
      check($sformatf("vec%0d_latency", i), lat, v[i].cy + 1);
      release_out();
      check($sformatf("vec%0d_idle_after", i), int'(in_ready), 1);
      check($sformatf("vec%0d_hold_hcf", i), int'(hcf), int'(v[i].h));
    end

    apply(8'd48, 8'd18, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in1 = 8'd9;
      in2 = 8'd3;
      @(posedge clk);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_hcf", int'(hcf), 6);
      check("bp_cycles", int'(cycles), 6);
    end
    in_valid = 0;
    release_out();
    @(posedge clk);
    #1;
    check("bp_no_capture_busy", int'(busy), 0);
    check("bp_hold_hcf", int'(hcf), 6);

    @(negedge clk);
    in1 = 8'd200;
    in2 = 8'd150;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midcalc_busy", int'(busy), 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_hcf", int'(hcf), 0);
    apply(8'd12, 8'd8, lat);
    check("after_abort_hcf", int'(hcf), 4);
    release_out();

    for (int i = 0; i < 300; i++) begin
      x = (i % 37 == 0) ? 8'd0 : 8'($urandom);
      y = 8'($urandom);
      apply(x, y, lat);
      check("rnd_hcf", int'(hcf), gcd_ref(int'(x), int'(y)));
      check("rnd_coprime", int'(coprime), int'(gcd_ref(int'(x), int'(y)) == 1));
      check("rnd_cycle_bound", int'(cycles <= 5'd17), 1);
      check("rnd_latency", lat, int'(cycles) + 1);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hcf_seq.md
# hcf_seq

Sequential, parametrised highest-common-factor engine using a one-step-per-cycle binary (Stein) GCD datapath behind valid/ready handshakes. It replaces the combinational subtract loop, which cannot be synthesised for arbitrary operands. It is intended for arithmetic subsystems that need the HCF of two N-bit unsigned operands in bounded latency. It also reports a coprime flag and the iteration count.

## Interface
Parameters:
- N, 8, operand and result width (N >= 2)
- CW, derived localparam $clog2(2*N+2), width of iteration counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine idle and able to accept operands
- in1  input  N  operand A, unsigned
- in2  input  N  operand B, unsigned
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- hcf  output  N  highest common factor
- coprime  output  1  hcf == 1
- cycles  output  CW  CALC-state cycles spent on this pair
- busy  output  1  state is not IDLE

## Operation
- States: IDLE, CALC, DONE. Internal regs: a, b (N bits), k ($clog2(N+1) bits), cnt (CW bits).
- IDLE: in_ready=1. On in_valid, the pair is accepted at that edge:
  - If either operand is 0, go to DONE with hcf = in1|in2 and cycles=0. gcd(0,0)=0.
  - Otherwise load a=in1, b=in2, k=0, cnt=0, and go to CALC.
- CALC: exactly one action per cycle, in priority order. cnt increments every CALC cycle.
  1. a==b: hcf=a<<k, go to DONE.
  2. a and b both even: a>>=1, b>>=1, k++.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. a>b: a=(a-b)>>1.
  6. else: b=(b-a)>>1.
- Subtractions in rules 5 and 6 are N-bit and never underflow. a<<k never exceeds N bits because hcf <= min(in1,in2).
- DONE: out_valid=1, and hcf, coprime and cycles are stable. When out_ready=1, go to IDLE. in_ready=0 in DONE, so there is no overlap of accept and deliver.
- in1/in2 are sampled only at the accepting edge. Later changes are ignored.
- in_valid while not IDLE is ignored. The source must hold it until in_ready.

## Timing
- Reset: state=IDLE, in_ready=1 (the cycle after reset deasserts), out_valid=0, busy=0, hcf=0, coprime=0, cycles=0.
- Reset mid-CALC or in DONE aborts the operation and discards any pending result.
- Latency: out_valid rises C+1 cycles after the accepting edge, where C = CALC cycle count. For zero operands it rises 1 cycle after acceptance.
- Bound: C <= 2N+1 for all nonzero operands. The counter never wraps.
- Result outputs change only on entry to DONE. They hold their value in IDLE until the next result.
- Throughput: one result per C+2 cycles minimum, with a 1-cycle IDLE gap after out_ready.

## Structure
- Package hcf_pkg holds the state enum (IDLE/CALC/DONE) and a function computing CW from N.
- One sub-module, hcf_step, is purely combinational. It implements the CALC priority rules: inputs a, b, k; outputs a_nxt, b_nxt, k_nxt, eq. It holds no state, so it can be unit-tested exhaustively for small N.
- The top level holds the FSM, registers and handshake.

## Test plan
- N=8, (48,18) -> hcf=6, coprime=0, cycles=6; out_valid 7 cycles after accept.
- N=8, (17,5) -> hcf=1, coprime=1, cycles=5; (255,255) -> hcf=255, cycles=1.
- N=8, (0,35) -> hcf=35, cycles=0, out_valid 1 cycle after accept; (0,0) -> hcf=0, coprime=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs stay stable, in_ready stays 0, and in_valid pulses are ignored.
- Reset asserted mid-CALC on (200,150). Next cycle: state IDLE, out_valid=0. A subsequent (12,8) yields 4.
- Random sweep (N=8 exhaustive, N=16 10k random) against a reference GCD. Check cycles <= 2N+1 and handshake protocol assertions.
